// File: rtl/accum_pkg.sv
// rtl/accum_pkg.sv - shared types and defaults for the accumulator feeder
package accum_pkg;

   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_N_CHANNEL  = 8;

   typedef enum logic [1:0] {
      INIT,
      FEED,
      STOP,
      CAPTURE
   } state_t;

   // The accumulator's channel counter wraps at its own width.
   function automatic int unsigned expected_cnt(input int unsigned n_channel,
                                                input int unsigned cnt_width);
      return n_channel % (32'd1 << cnt_width);
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock first-word-fall-through FIFO
module sync_fifo #(
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] pop_data,
   output logic                  full,
   output logic                  empty
);

   localparam int AW = $clog2(FIFO_DEPTH);

   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;
   logic [AW:0]           count;
   logic                  push_ok;
   logic                  pop_ok;

   assign push_ok  = push && !full;
   assign pop_ok   = pop && !empty;
   assign full     = (count == (AW+1)'(FIFO_DEPTH));
   assign empty    = (count == '0);
   assign pop_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
         case ({push_ok, pop_ok})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/accum_feeder.sv
// rtl/accum_feeder.sv - feeds buffered partial sums into a channel accumulator
// and returns each finalised frame sum on a valid/ready stream.
module accum_feeder
   import accum_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int N_CHANNEL  = DEF_N_CHANNEL,
   parameter int CNT_WIDTH  = $clog2(N_CHANNEL),
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  s_valid,
   input  logic [DATA_WIDTH-1:0] s_data,
   output logic                  s_ready,
   output logic [DATA_WIDTH-1:0] acc_data,
   output logic                  acc_rec,
   output logic                  acc_stop,
   input  logic [DATA_WIDTH-1:0] acc_result,
   input  logic [CNT_WIDTH-1:0]  acc_cnt,
   output logic                  m_valid,
   output logic [DATA_WIDTH-1:0] m_data,
   input  logic                  m_ready,
   output logic                  err_cnt_mismatch
);

   localparam int CHW = $clog2(N_CHANNEL + 1);
   localparam logic [CNT_WIDTH-1:0] EXP_CNT   = CNT_WIDTH'(expected_cnt(N_CHANNEL, CNT_WIDTH));
   localparam logic [CHW-1:0]       LAST_CHAN = CHW'(N_CHANNEL - 1);

   state_t                state, state_nxt;
   logic [CHW-1:0]        chan_cnt;
   logic                  fifo_full, fifo_empty, fifo_push, fifo_pop;
   logic [DATA_WIDTH-1:0] fifo_data, m_data_q;
   logic                  m_valid_q, err_q;
   logic                  rec_c, stop_c, chk_c;

   assign s_ready   = !fifo_full && !rst;
   assign fifo_push = s_valid && s_ready;
   assign fifo_pop  = rec_c;

   sync_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (fifo_push),
      .push_data (s_data),
      .pop       (fifo_pop),
      .pop_data  (fifo_data),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // Strobes are suppressed while rst is high even though state still holds its old value.
   always_comb begin
      state_nxt = state;
      rec_c     = 1'b0;
      stop_c    = 1'b0;
      chk_c     = 1'b0;
      if (!rst) begin
         case (state)
            INIT: begin
               stop_c    = 1'b1;
               state_nxt = FEED;
            end
            FEED: begin
               if (!fifo_empty) begin
                  rec_c = 1'b1;
                  if (chan_cnt == LAST_CHAN) state_nxt = STOP;
               end
            end
            STOP: begin
               if (!m_valid_q) begin
                  stop_c    = 1'b1;
                  chk_c     = 1'b1;
                  state_nxt = CAPTURE;
               end
            end
            CAPTURE: state_nxt = FEED;
            default: state_nxt = INIT;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= INIT;
         chan_cnt  <= '0;
         m_valid_q <= 1'b0;
         m_data_q  <= '0;
         err_q     <= 1'b0;
      end else begin
         state <= state_nxt;
         if (fifo_pop) chan_cnt <= (chan_cnt == LAST_CHAN) ? '0 : chan_cnt + CHW'(1);
         if (chk_c && (acc_cnt != EXP_CNT)) err_q <= 1'b1;
         if (state == CAPTURE) begin
            m_valid_q <= 1'b1;
            m_data_q  <= acc_result;
         end else if (m_valid_q && m_ready) begin
            m_valid_q <= 1'b0;
         end
      end
   end

   assign acc_rec          = rec_c;
   assign acc_stop         = stop_c;
   assign acc_data         = rec_c ? fifo_data : '0;
   assign m_valid          = m_valid_q && !rst;
   assign m_data           = rst ? '0 : m_data_q;
   assign err_cnt_mismatch = err_q && !rst;

endmodule

// File: tb/tb_accum_feeder.sv
// tb/tb_accum_feeder.sv - directed bench for accum_feeder with an accumulator model
module tb_accum_feeder;

   localparam int DW = 32;
   localparam int NC = 8;
   localparam int CW = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          s_valid = 1'b0;
   logic [DW-1:0] s_data = '0;
   logic          s_ready;
   logic [DW-1:0] acc_data;
   logic          acc_rec, acc_stop;
   logic [DW-1:0] acc_result;
   logic [CW-1:0] acc_cnt;
   logic          m_valid;
   logic [DW-1:0] m_data;
   logic          m_ready = 1'b1;
   logic          err_cnt_mismatch;

   always #5 clk = ~clk;

   accum_feeder #(
      .DATA_WIDTH (DW),
      .N_CHANNEL  (NC),
      .CNT_WIDTH  (CW),
      .FIFO_DEPTH (4)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .s_valid          (s_valid),
      .s_data           (s_data),
      .s_ready          (s_ready),
      .acc_data         (acc_data),
      .acc_rec          (acc_rec),
      .acc_stop         (acc_stop),
      .acc_result       (acc_result),
      .acc_cnt          (acc_cnt),
      .m_valid          (m_valid),
      .m_data           (m_data),
      .m_ready          (m_ready),
      .err_cnt_mismatch (err_cnt_mismatch)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Accumulator model: sums on rec, finalises and clears on stop.
   logic [DW-1:0] mod_sum = '0;
   logic [DW-1:0] mod_res = '0;
   logic [CW-1:0] mod_cnt = '0;
   bit            force_bad = 1'b0;

   always @(posedge clk) begin
      if (acc_rec) begin
         mod_sum <= mod_sum + acc_data;
         mod_cnt <= CW'(mod_cnt + 1);
      end
      if (acc_stop) begin
         mod_res <= mod_sum;
         mod_sum <= '0;
         mod_cnt <= '0;
      end
   end
   assign acc_result = mod_res;
   assign acc_cnt    = (force_bad && acc_stop) ? CW'(5) : mod_cnt;

   // Producer: drains a word queue onto s_valid/s_data.
   logic [DW-1:0] pq[$];
   bit            toggle_mode = 1'b0;
   bit            phase = 1'b0;
   bit            hs_q = 1'b0;

   always @(posedge clk) hs_q <= s_valid && s_ready;

   always @(negedge clk) begin
      if (hs_q && pq.size() > 0) void'(pq.pop_front());
      phase = !phase;
      if (pq.size() > 0 && (!toggle_mode || phase)) begin
         s_valid = 1'b1;
         s_data  = pq[0];
      end else begin
         s_valid = 1'b0;
         s_data  = '0;
      end
   end

   // Monitor.
   int            cyc = 0;
   logic [DW-1:0] rec_q[$];
   logic [DW-1:0] res_q[$];
   int            last_rec_cyc = 0, stop_cyc = 0, first_mv_cyc = 0, err_rise_cyc = -1;
   int            mv_cycles = 0, overlap = 0, stop_held = 0;
   bit            prev_mv = 1'b0, prev_err = 1'b0;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (acc_rec) begin
         rec_q.push_back(acc_data);
         last_rec_cyc = cyc;
      end
      if (acc_stop) stop_cyc = cyc;
      if (acc_rec && acc_stop) overlap++;
      if (acc_stop && m_valid) stop_held++;
      if (m_valid) mv_cycles++;
      if (m_valid && !prev_mv) first_mv_cyc = cyc;
      if (m_valid && m_ready) res_q.push_back(m_data);
      if (err_cnt_mismatch && !prev_err) err_rise_cyc = cyc;
      prev_mv  = m_valid;
      prev_err = err_cnt_mismatch;
   end

   task automatic wait_results(input int n, input int budget);
      int k = 0;
      while (res_q.size() < n && k < budget) begin
         @(negedge clk);
         k++;
      end
      check("result_arrival", DW'(res_q.size() >= n), DW'(1));
   endtask

   task automatic push_frame(input logic [DW-1:0] base, input logic [DW-1:0] step);
      for (int k = 0; k < NC; k++) pq.push_back(base + step * DW'(k));
   endtask

   function automatic logic [DW-1:0] res_at(input int idx);
      return (res_q.size() > idx) ? res_q[idx] : 32'hDEADBEEF;
   endfunction

   typedef struct {
      logic [DW-1:0] base;
      logic [DW-1:0] step;
      bit            toggle;
      logic [DW-1:0] exp_sum;
   } vec_t;

   vec_t tbl[5];

   initial begin
      tbl[0] = '{32'd1,        32'd1,        1'b0, 32'd36};
      tbl[1] = '{32'd1,        32'd1,        1'b1, 32'd36};
      tbl[2] = '{32'hFFFFFFFF, 32'd0,        1'b0, 32'hFFFFFFF8};
      tbl[3] = '{32'd10,       32'd5,        1'b1, 32'd220};
      tbl[4] = '{32'h80000000, 32'h80000000, 1'b0, 32'd0};

      // Reset state and the INIT flush pulse.
      repeat (3) @(posedge clk);
      #1;
      check("rst_ctrl", DW'({s_ready, acc_rec, acc_stop, m_valid, err_cnt_mismatch}), DW'(0));
      check("rst_m_data", m_data, '0);
      rst = 1'b0;
      @(negedge clk);
      check("init_stop", DW'(acc_stop), DW'(1));
      check("init_flags", DW'({m_valid, s_ready, err_cnt_mismatch}), DW'(3'b010));
      @(negedge clk);
      check("init_stop_once", DW'(acc_stop), DW'(0));

      // Table-driven frames with m_ready held high.
      for (int i = 0; i < 5; i++) begin
         bit ok;
         rec_q.delete();
         res_q.delete();
         mv_cycles   = 0;
         toggle_mode = tbl[i].toggle;
         push_frame(tbl[i].base, tbl[i].step);
         wait_results(1, 200);
         repeat (4) @(negedge clk);
         check($sformatf("sum_%0d", i), res_at(0), tbl[i].exp_sum);
         check($sformatf("rec_count_%0d", i), DW'(rec_q.size()), DW'(NC));
         ok = (rec_q.size() == NC);
         for (int k = 0; k < NC && ok; k++)
            if (rec_q[k] !== tbl[i].base + tbl[i].step * DW'(k)) ok = 1'b0;
         check($sformatf("rec_data_%0d", i), DW'(ok), DW'(1));
         check($sformatf("stop_lat_%0d", i), DW'(stop_cyc - last_rec_cyc), DW'(1));
         check($sformatf("mv_lat_%0d", i), DW'(first_mv_cyc - last_rec_cyc), DW'(3));
         check($sformatf("mv_pulse_%0d", i), DW'(mv_cycles), DW'(1));
      end
      toggle_mode = 1'b0;

      // Back-pressure: held result stalls the next stop and eventually the input.
      begin
         int k = 0;
         @(posedge clk);
         #1 m_ready = 1'b0;
         res_q.delete();
         push_frame(32'd1, 32'd1);
         push_frame(32'hFFFFFFFF, 32'd0);
         push_frame(32'd1, 32'd0);
         while (s_ready && k < 300) begin
            @(negedge clk);
            k++;
         end
         check("bp_s_ready_drop", DW'(s_ready), DW'(0));
         check("bp_m_valid", DW'(m_valid), DW'(1));
         check("bp_m_data", m_data, 32'd36);
         repeat (5) @(negedge clk);
         check("bp_m_data_stable", m_data, 32'd36);
         check("bp_no_stop_held", DW'(stop_held), DW'(0));
         @(posedge clk);
         #1 m_ready = 1'b1;
         wait_results(3, 300);
         check("bp_res0", res_at(0), 32'd36);
         check("bp_res1", res_at(1), 32'hFFFFFFF8);
         check("bp_res2", res_at(2), 32'd8);
      end

      // Counter mismatch is flagged the cycle after the stop and stays sticky.
      check("err_before", DW'(err_cnt_mismatch), DW'(0));
      res_q.delete();
      force_bad = 1'b1;
      push_frame(32'd1, 32'd0);
      wait_results(1, 200);
      force_bad = 1'b0;
      check("err_set", DW'(err_cnt_mismatch), DW'(1));
      check("err_timing", DW'(err_rise_cyc - stop_cyc), DW'(1));
      check("err_frame_sum", res_at(0), 32'd8);
      res_q.delete();
      push_frame(32'd2, 32'd0);
      wait_results(1, 200);
      check("err_good_sum", res_at(0), 32'd16);
      check("err_sticky", DW'(err_cnt_mismatch), DW'(1));

      // Reset mid-frame after three words have been fed.
      begin
         int k = 0;
         res_q.delete();
         rec_q.delete();
         push_frame(32'd3, 32'd0);
         while (rec_q.size() < 3 && k < 200) begin
            @(negedge clk);
            k++;
         end
         check("mid_rec3", DW'(rec_q.size() >= 3), DW'(1));
         @(posedge clk);
         #1 rst = 1'b1;
         pq.delete();
         @(posedge clk);
         #1;
         check("mid_rst_ctrl", DW'({s_ready, acc_rec, acc_stop, m_valid, err_cnt_mismatch}), DW'(0));
         check("mid_rst_data", DW'({m_data, acc_data} != '0), DW'(0));
         rst = 1'b0;
         @(negedge clk);
         check("mid_init_stop", DW'(acc_stop), DW'(1));
         @(negedge clk);
         check("mid_init_once", DW'(acc_stop), DW'(0));
         check("mid_err_clear", DW'(err_cnt_mismatch), DW'(0));
         push_frame(32'd1, 32'd0);
         wait_results(1, 200);
         check("mid_next_sum", res_at(0), 32'd8);
         check("mid_err_still0", DW'(err_cnt_mismatch), DW'(0));
      end

      check("no_rec_stop_overlap", DW'(overlap), DW'(0));
      check("no_stop_while_held", DW'(stop_held), DW'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got cycle %0d expected finish", cyc);
      $fatal(1, "timeout");
   end

endmodule
